// File: rtl/aexm_dmem_ctl_if.sv
// Cache-side request/ack bus of the AEXM data-memory controller.
// The controller drives the master side; the data cache sits on the slave side.
interface aexm_dmem_ctl_if;
  logic        dc_req;
  logic        dc_we;
  logic [29:0] dc_addr;
  logic [3:0]  dc_sel;
  logic [31:0] dc_wdata;
  logic        dc_ack;
  logic [31:0] dc_rdata;

  modport master (
    output dc_req, dc_we, dc_addr, dc_sel, dc_wdata,
    input  dc_ack, dc_rdata
  );

  modport slave (
    input  dc_req, dc_we, dc_addr, dc_sel, dc_wdata,
    output dc_ack, dc_rdata
  );
endinterface

// File: rtl/aexm_dmem_ctl.sv
// AEXM data-memory access controller: lane decode, cache req/ack handshake, pipeline stall.
// Define AEXM_DMEM_TIMEOUT_EN to abort an unacknowledged access after 2^TIMEOUT_W-1 wait cycles.
module aexm_dmem_ctl #(
  parameter int TIMEOUT_W = 8
) (
  input  logic                  gclk,
  input  logic                  grst,
  input  logic                  mem_valid,
  input  logic                  mem_we,
  input  logic [1:0]            mem_size,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic                  x_en,
  aexm_dmem_ctl_if.master       dc,
  output logic [31:0]           aexm_dcache_datai,
  output logic [3:0]            rDWBSEL,
  output logic                  dmem_stall,
  output logic                  dmem_err
);

  if (TIMEOUT_W < 1) begin : gBadW
    $error("TIMEOUT_W must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;
  state_t state;

  logic [3:0] laneSel;
  logic       misAlign;
  logic       accept;

  // Big-endian lanes: byte 0 of a word lives in bits [31:24] (sel bit 3).
  always_comb begin
    laneSel  = 4'h0;
    misAlign = 1'b1;
    case (mem_size)
      2'd0: begin
        misAlign = 1'b0;
        case (mem_addr[1:0])
          2'd0:    laneSel = 4'h8;
          2'd1:    laneSel = 4'h4;
          2'd2:    laneSel = 4'h2;
          default: laneSel = 4'h1;
        endcase
      end
      2'd1: begin
        misAlign = mem_addr[0];
        laneSel  = mem_addr[1] ? 4'h3 : 4'hC;
      end
      2'd2: begin
        misAlign = |mem_addr[1:0];
        laneSel  = 4'hF;
      end
      default: begin
        misAlign = 1'b1;
        laneSel  = 4'h0;
      end
    endcase
  end

  assign accept     = (state == IDLE) && mem_valid && x_en && !misAlign;
  assign dmem_stall = accept || ((state == BUSY) && !dc.dc_ack);

`ifdef AEXM_DMEM_TIMEOUT_EN
  // The counter holds completed wait cycles; the final one is the cycle it equals 2^W-2 without ack.
  localparam logic [TIMEOUT_W-1:0] WaitLast = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  logic [TIMEOUT_W-1:0] waitCnt;
`endif

  always_ff @(posedge gclk) begin
    if (!grst) begin
      state             <= IDLE;
      dc.dc_req         <= 1'b0;
      dc.dc_we          <= 1'b0;
      dc.dc_addr        <= '0;
      dc.dc_sel         <= '0;
      dc.dc_wdata       <= '0;
      aexm_dcache_datai <= '0;
      rDWBSEL           <= 4'hF;
      dmem_err          <= 1'b0;
`ifdef AEXM_DMEM_TIMEOUT_EN
      waitCnt           <= '0;
`endif
    end else begin
      dmem_err <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_valid && x_en) begin
            if (misAlign) begin
              state    <= ERR;
              dmem_err <= 1'b1;
            end else begin
              dc.dc_addr  <= mem_addr[31:2];
              dc.dc_sel   <= laneSel;
              dc.dc_we    <= mem_we;
              dc.dc_wdata <= mem_wdata;
              dc.dc_req   <= 1'b1;
              state       <= BUSY;
`ifdef AEXM_DMEM_TIMEOUT_EN
              waitCnt     <= '0;
`endif
            end
          end
        end
        BUSY: begin
          if (dc.dc_ack) begin
            dc.dc_req <= 1'b0;
            dc.dc_we  <= 1'b0;
            rDWBSEL   <= dc.dc_sel;
            if (!dc.dc_we) aexm_dcache_datai <= dc.dc_rdata;
            state     <= IDLE;
          end
`ifdef AEXM_DMEM_TIMEOUT_EN
          else if (waitCnt == WaitLast) begin
            dc.dc_req <= 1'b0;
            dc.dc_we  <= 1'b0;
            dmem_err  <= 1'b1;
            state     <= ERR;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
`endif
        end
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aexm_dmem_ctl.sv
// Self-checking bench for aexm_dmem_ctl: directed plan steps plus randomized accesses
// checked against an arithmetic lane/alignment model and a cache-result scoreboard.
module tb_aexm_dmem_ctl;
  localparam int TW = 4;

  logic        gclk = 1'b0;
  logic        grst;
  logic        mem_valid, mem_we, x_en;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] datai;
  logic [3:0]  wbsel;
  logic        stall, err;

  aexm_dmem_ctl_if dcb ();

  aexm_dmem_ctl #(.TIMEOUT_W(TW)) dut (
    .gclk              (gclk),
    .grst              (grst),
    .mem_valid         (mem_valid),
    .mem_we            (mem_we),
    .mem_size          (mem_size),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .x_en              (x_en),
    .dc                (dcb.master),
    .aexm_dcache_datai (datai),
    .rDWBSEL           (wbsel),
    .dmem_stall        (stall),
    .dmem_err          (err)
  );

  always #5 gclk = ~gclk;

  int total = 0;
  int bad   = 0;
  logic [31:0] mData;
  logic [3:0]  mSel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Caller arrives just after a falling edge; the task leaves at the same phase.
  task automatic acc(input logic we, input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rd, input int waits);
    int n, off;
    bit mis;
    logic [3:0] es;
    n   = 1 << sz;
    off = int'(a[1:0]);
    mis = (sz == 2'd3) || (off % n != 0);
    es  = mis ? 4'h0 : 4'(((1 << n) - 1) << (4 - n - off));
    mem_valid = 1'b1; mem_we = we; mem_size = sz; mem_addr = a; mem_wdata = wd; x_en = 1'b1;
    dcb.dc_ack = 1'b0;
    #1;
    if (mis) begin
      chk("mis_stall0", {31'b0, stall}, 0);
      @(negedge gclk); mem_valid = 1'b0; #1;
      chk("mis_err", {31'b0, err}, 1);
      chk("mis_noreq", {31'b0, dcb.dc_req}, 0);
      chk("mis_stall1", {31'b0, stall}, 0);
      chk("mis_datai", datai, mData);
      chk("mis_sel", {28'b0, wbsel}, {28'b0, mSel});
      @(negedge gclk); #1;
      chk("mis_err_clr", {31'b0, err}, 0);
      return;
    end
    chk("acc_stall", {31'b0, stall}, 1);
    chk("req_not_early", {31'b0, dcb.dc_req}, 0);
    @(negedge gclk); #1;
    chk("req", {31'b0, dcb.dc_req}, 1);
    chk("addr", {2'b0, dcb.dc_addr}, {2'b0, a[31:2]});
    chk("dcsel", {28'b0, dcb.dc_sel}, {28'b0, es});
    chk("dcwe", {31'b0, dcb.dc_we}, {31'b0, we});
    if (we) chk("wdata", dcb.dc_wdata, wd);
    for (int i = 0; i < waits; i++) begin
      chk("wait_stall", {31'b0, stall}, 1);
      chk("wait_req", {31'b0, dcb.dc_req}, 1);
      @(negedge gclk); #1;
    end
    dcb.dc_ack = 1'b1; dcb.dc_rdata = rd; #1;
    chk("ack_stall", {31'b0, stall}, 0);
    @(negedge gclk); dcb.dc_ack = 1'b0; mem_valid = 1'b0; #1;
    if (!we) mData = rd;
    mSel = es;
    chk("done_req", {31'b0, dcb.dc_req}, 0);
    chk("done_we", {31'b0, dcb.dc_we}, 0);
    chk("done_sel", {28'b0, wbsel}, {28'b0, mSel});
    chk("done_datai", datai, mData);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [1:0]  sz;
    logic [31:0] a;
    int n;
    grst = 1'b0; mem_valid = 1'b0; mem_we = 1'b0; mem_size = 2'd0; mem_addr = '0;
    mem_wdata = '0; x_en = 1'b0; dcb.dc_ack = 1'b0; dcb.dc_rdata = '0;
    mData = '0; mSel = 4'hF;
    repeat (2) @(negedge gclk);
    #1;
    chk("rst_req", {31'b0, dcb.dc_req}, 0);
    chk("rst_we", {31'b0, dcb.dc_we}, 0);
    chk("rst_addr", {2'b0, dcb.dc_addr}, 0);
    chk("rst_sel", {28'b0, dcb.dc_sel}, 0);
    chk("rst_wdata", dcb.dc_wdata, 0);
    chk("rst_datai", datai, 0);
    chk("rst_wbsel", {28'b0, wbsel}, 32'hF);
    chk("rst_err", {31'b0, err}, 0);
    chk("rst_stall", {31'b0, stall}, 0);
    grst = 1'b1;
    @(negedge gclk); #1;

    acc(1'b0, 2'd2, 32'h100, 32'h0, 32'hDEADBEEF, 2);
    chk("t1_datai", datai, 32'hDEADBEEF);
    acc(1'b1, 2'd0, 32'h203, 32'h5A5A5A5A, 32'h11111111, 0);
    chk("t2_datai_kept", datai, 32'hDEADBEEF);
    chk("t2_sel", {28'b0, wbsel}, 32'h1);
    acc(1'b0, 2'd1, 32'h102, 32'h0, 32'hCAFE0123, 0);
    chk("t3_sel_half", {28'b0, wbsel}, 32'h3);
    acc(1'b0, 2'd2, 32'h104, 32'h0, 32'h0BADF00D, 0);
    chk("t3_sel_word", {28'b0, wbsel}, 32'hF);
    acc(1'b0, 2'd2, 32'h101, 32'h0, 32'h0, 0);

    // Reset while a load is outstanding, then a stray ack.
    mem_valid = 1'b1; mem_we = 1'b0; mem_size = 2'd2; mem_addr = 32'h200; x_en = 1'b1;
    @(negedge gclk); #1;
    chk("mid_req", {31'b0, dcb.dc_req}, 1);
    grst = 1'b0;
    @(negedge gclk); #1;
    chk("mid_rst_req", {31'b0, dcb.dc_req}, 0);
    chk("mid_rst_sel", {28'b0, wbsel}, 32'hF);
    chk("mid_rst_datai", datai, 0);
    mData = '0; mSel = 4'hF;
    grst = 1'b1; mem_valid = 1'b0; dcb.dc_ack = 1'b1; dcb.dc_rdata = 32'h12345678;
    @(negedge gclk); dcb.dc_ack = 1'b0; #1;
    chk("late_ack_datai", datai, mData);
    chk("late_ack_sel", {28'b0, wbsel}, {28'b0, mSel});
    chk("late_ack_req", {31'b0, dcb.dc_req}, 0);

    // Never-acked access.
    mem_valid = 1'b1; mem_we = 1'b0; mem_size = 2'd2; mem_addr = 32'h300; x_en = 1'b1;
    @(negedge gclk); #1;
`ifdef AEXM_DMEM_TIMEOUT_EN
    cnt = 0;
    while (dcb.dc_req && cnt < 200) begin
      cnt++;
      @(negedge gclk); #1;
    end
    chk("to_wait_cycles", cnt, (1 << TW) - 1);
    chk("to_err", {31'b0, err}, 1);
    chk("to_stall", {31'b0, stall}, 0);
    chk("to_datai", datai, mData);
    chk("to_sel", {28'b0, wbsel}, {28'b0, mSel});
    mem_valid = 1'b0;
    @(negedge gclk); #1;
    chk("to_err_clr", {31'b0, err}, 0);
`else
    cnt = 0;
    repeat (99) @(negedge gclk);
    #1;
    chk("hold_req_100", {31'b0, dcb.dc_req}, 1);
    chk("hold_stall_100", {31'b0, stall}, 1);
    chk("hold_noerr", {31'b0, err}, 0);
    dcb.dc_ack = 1'b1; dcb.dc_rdata = 32'hA5A50F0F;
    @(negedge gclk); dcb.dc_ack = 1'b0; mem_valid = 1'b0; #1;
    mData = 32'hA5A50F0F; mSel = 4'hF;
    chk("hold_done_datai", datai, mData);
    chk("hold_done_sel", {28'b0, wbsel}, {28'b0, mSel});
`endif

    for (int k = 0; k < 40; k++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      n  = 1 << sz;
      if (sz != 2'd3 && $urandom_range(0, 3) != 0) a[1:0] = a[1:0] & 2'(~(n - 1));
      if ($urandom_range(0, 4) == 0) begin
        mem_valid = 1'b1; mem_size = sz; mem_addr = a; x_en = 1'b0; #1;
        chk("xen_stall", {31'b0, stall}, 0);
        @(negedge gclk); #1;
        chk("xen_noreq", {31'b0, dcb.dc_req}, 0);
      end
      acc(1'($urandom_range(0, 1)), sz, a, $urandom, $urandom, int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
